// File: rtl/md_unit.sv
// md_unit - EX-stage multiply/divide controller.
//
// Owns the HI/LO registers. MULT/MULTU go through a single-cycle 64-bit
// multiplier. DIV/DIVU go through a 32-step restoring divider, one step per
// cycle. While an operation is in flight, stall_req holds IF/ID/EX. MTHI and
// MTLO write HI/LO directly. A flush aborts any operation without touching
// HI/LO.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      EX holds a valid instruction (held high while stalled)
//   funct[5:0] FUNCT code: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B,
//              MTHI 0x11, MTLO 0x13; other codes are ignored
//   op_a[31:0] rs operand (dividend / multiplicand / MTHI, MTLO source)
//   op_b[31:0] rt operand (divisor / multiplier)
//   flush      flush of EX; highest priority
//   stall_req  hold IF/ID/EX this cycle (combinational)
//   busy       state is MUL or DIV
//   hi[31:0]   HI register
//   lo[31:0]   LO register
module md_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, a_d;         // multiplicand, or dividend/quotient shift register
  logic [31:0] b_q, b_d;         // multiplier, or divisor magnitude
  logic [31:0] rem_q, rem_d;     // partial remainder
  logic [4:0]  cnt_q, cnt_d;     // divide step counter
  logic        sgn_q, sgn_d;     // MULT (signed) vs MULTU
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  logic        is_mul, is_div, is_signed;
  logic [31:0] abs_a, abs_b;
  logic [63:0] mul_a, mul_b, product;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_next, quo_next;

  assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div    = (funct == F_DIV)  || (funct == F_DIVU);
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);

  // DIV works on magnitudes; the signs are re-applied after the last step.
  assign abs_a = (is_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
  assign abs_b = (is_signed && op_b[31]) ? (32'd0 - op_b) : op_b;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both two's-complement and unsigned operands.
  assign mul_a   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign mul_b   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign product = mul_a * mul_b;

  // Restoring step: the shifted remainder needs 33 bits; when it is >= the
  // divisor, the difference is below the divisor and fits in 32 bits.
  assign rem_shift = {rem_q, a_q[31]};
  assign rem_ge    = (rem_shift >= {1'b0, b_q});
  assign rem_next  = rem_ge ? (rem_shift[31:0] - b_q) : rem_shift[31:0];
  assign quo_next  = {a_q[30:0], rem_ge};

  // Stall is gated by reset so it reads low while the block is held in reset.
  assign stall_req = rst_n & ~flush &
                     (((state_q == S_IDLE) & start & (is_mul | is_div)) |
                      (state_q == S_MUL) | (state_q == S_DIV));
  assign busy = (state_q == S_MUL) || (state_q == S_DIV);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_mul) begin
              a_d     = op_a;
              b_d     = op_b;
              sgn_d   = is_signed;
              state_d = S_MUL;
            end else if (is_div) begin
              if (op_b == 32'd0) begin
                lo_d    = 32'hFFFF_FFFF;
                hi_d    = op_a;
                state_d = S_DONE;
              end else begin
                a_d       = abs_a;
                b_d       = abs_b;
                rem_d     = 32'd0;
                cnt_d     = 5'd0;
                neg_quo_d = is_signed & (op_a[31] ^ op_b[31]);
                neg_rem_d = is_signed & op_a[31];
                state_d   = S_DIV;
              end
            end else if (funct == F_MTHI) begin
              hi_d = op_a;
            end else if (funct == F_MTLO) begin
              lo_d = op_a;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL: begin
          hi_d    = product[63:32];
          lo_d    = product[31:0];
          state_d = S_DONE;
        end
        S_DIV: begin
          a_d   = quo_next;
          rem_d = rem_next;
          if (cnt_q == 5'd31) begin
            lo_d    = neg_quo_q ? (32'd0 - quo_next) : quo_next;
            hi_d    = neg_rem_q ? (32'd0 - rem_next) : rem_next;
            cnt_d   = 5'd0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_DONE: begin
          // start still belongs to the finished instruction here.
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rem_q     <= 32'd0;
      cnt_q     <= 5'd0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit. Expected HI/LO/stall counts are pushed to
// a scoreboard queue when an instruction is issued and popped when the DUT
// releases the stall (DONE) or, for MTHI/MTLO, on the following cycle.
module tb_md_unit;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b;
  logic        stall_req, busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] hi_m, lo_m;   // architectural HI/LO as the bench believes them

  always #5 clk = ~clk;

  md_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .funct     (funct),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: native 64-bit multiply and native divide on magnitudes.
  function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb;
    logic [63:0] p;
    logic [31:0] ua, ub, q, r;
    logic        sg;
    e.hi = hi_m; e.lo = lo_m; e.stalls = 0;
    case (f)
      F_MULT: begin
        sa = $signed(a); sb = $signed(b); p = sa * sb;
        e.hi = p[63:32]; e.lo = p[31:0]; e.stalls = 2;
      end
      F_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32]; e.lo = p[31:0]; e.stalls = 2;
      end
      F_DIV, F_DIVU: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.stalls = 1;
        end else begin
          sg = (f == F_DIV);
          ua = (sg && a[31]) ? -a : a;
          ub = (sg && b[31]) ? -b : b;
          q = ua / ub;
          r = ua % ub;
          if (sg && (a[31] ^ b[31])) q = -q;
          if (sg && a[31]) r = -r;
          e.hi = r; e.lo = q; e.stalls = 33;
        end
      end
      F_MTHI: e.hi = a;
      F_MTLO: e.lo = a;
      default: e.stalls = 0;
    endcase
    return e;
  endfunction

  // Issue one instruction at posedge+1, follow it to completion, and leave
  // with inputs changeable at posedge+1 of the cycle after DONE.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
    exp_t got_e;
    int   stalls = 0;
    int   cyc = 0;
    logic saw_busy = 1'b0;
    sb_q.push_back(e);
    start = 1'b1; funct = f; op_a = a; op_b = b;
    @(negedge clk);
    if (e.stalls == 0) begin
      check_val({tag, "_nostall"}, 64'(stall_req), 64'd0);
      check_val({tag, "_prev"}, {hi, lo}, {hi_m, lo_m});
      @(posedge clk); #1;
      start = 1'b0;
      got_e = sb_q.pop_front();
      check_val({tag, "_hilo"}, {hi, lo}, {got_e.hi, got_e.lo});
    end else begin
      while (stall_req && cyc < 100) begin
        stalls++; cyc++;
        @(posedge clk); @(negedge clk);
        if (stall_req && busy) saw_busy = 1'b1;
      end
      got_e = sb_q.pop_front();
      check_val({tag, "_stalls"}, 64'(stalls), 64'(got_e.stalls));
      check_val({tag, "_hilo"}, {hi, lo}, {got_e.hi, got_e.lo});
      if (got_e.stalls > 1) check_val({tag, "_busy"}, 64'(saw_busy), 64'd1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    hi_m = e.hi;
    lo_m = e.lo;
  endtask

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input int s);
    exp_t e;
    e.hi = h; e.lo = l; e.stalls = s;
    return e;
  endfunction

  initial begin
    logic [5:0]  rf;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = 6'd0; op_a = 32'd0; op_b = 32'd0;
    hi_m = 32'd0; lo_m = 32'd0;
    #12;
    check_val("rst_hilo", {hi, lo}, 64'd0);
    check_val("rst_stall", 64'(stall_req), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply
    run_op("mult_neg3x5",  F_MULT,  32'hFFFF_FFFD, 32'd5, mk(32'hFFFF_FFFF, 32'hFFFF_FFF1, 2));
    run_op("multu_neg3x5", F_MULTU, 32'hFFFF_FFFD, 32'd5, mk(32'h0000_0004, 32'hFFFF_FFF1, 2));

    // Divide
    run_op("divu_100_7",  F_DIVU, 32'd100, 32'd7, mk(32'd2, 32'd14, 33));
    run_op("div_m7_2",    F_DIV,  32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 33));
    run_op("div_ovf",     F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, mk(32'd0, 32'h8000_0000, 33));
    run_op("divu_zero",   F_DIVU, 32'h1234_5678, 32'd0, mk(32'h1234_5678, 32'hFFFF_FFFF, 1));

    // Model-driven mixed operations
    for (int i = 0; i < 6; i++) begin
      case (i % 4)
        0: rf = F_MULT;
        1: rf = F_MULTU;
        2: rf = F_DIV;
        default: rf = F_DIVU;
      endcase
      ra = $urandom;
      rb = (i < 4) ? $urandom : $urandom_range(1, 300);
      run_op("rand_op", rf, ra, rb, model(rf, ra, rb));
    end

    // Flush mid-divide leaves HI/LO untouched
    run_op("mthi_pre", F_MTHI, 32'hAAAA_0000, 32'd0, mk(32'hAAAA_0000, lo_m, 0));
    run_op("mtlo_pre", F_MTLO, 32'h0000_5555, 32'd0, mk(hi_m, 32'h0000_5555, 0));
    start = 1'b1; funct = F_DIVU; op_a = 32'd100; op_b = 32'd7;
    repeat (10) @(posedge clk);
    #1; flush = 1'b1;
    @(negedge clk);
    check_val("flush_stall_drop", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check_val("flush_idle_busy", 64'(busy), 64'd0);
    check_val("flush_hilo", {hi, lo}, {32'hAAAA_0000, 32'h0000_5555});
    @(posedge clk); #1;
    run_op("divu_after_flush", F_DIVU, 32'd100, 32'd7, mk(32'd2, 32'd14, 33));

    // Back-to-back MULT then MTLO
    run_op("mult_6x7", F_MULT, 32'd6, 32'd7, mk(32'd0, 32'd42, 2));
    run_op("mtlo_b2b", F_MTLO, 32'd1, 32'd0, mk(32'd0, 32'd1, 0));

    // Asynchronous reset in the middle of a divide
    start = 1'b1; funct = F_DIVU; op_a = 32'd1000; op_b = 32'd3;
    repeat (13) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check_val("rst_mid_hilo", {hi, lo}, 64'd0);
    check_val("rst_mid_stall", 64'(stall_req), 64'd0);
    check_val("rst_mid_busy", 64'(busy), 64'd0);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    @(posedge clk); #1;
    run_op("mtlo_after_rst", F_MTLO, 32'h0000_0077, 32'd0, mk(32'd0, 32'h0000_0077, 0));
    run_op("multu_after_rst", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 32'h0000_0001, 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide controller in the EX stage. Owns the HI/LO registers and sequences MULT/MULTU through a single-cycle multiplier and DIV/DIVU through an iterative 32-step restoring divider. Raises a stall request that holds the pipeline while an operation is in flight. Services MTHI/MTLO writes, and aborts cleanly on a pipeline flush.

## Interface
- No parameters; width fixed at 32 bits.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  EX holds a valid instruction; held high by the pipeline while stalled
- funct  in  6  FUNCT code from the decode stage: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13; any other value is ignored
- op_a  in  32  rs operand (dividend / multiplicand / MTHI, MTLO source)
- op_b  in  32  rt operand (divisor / multiplier)
- flush  in  1  exception/branch flush of EX; highest priority
- stall_req  out  1  hold IF/ID/EX this cycle
- busy  out  1  state is MUL or DIV
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, MUL, DIV, DONE.
- Reset: state IDLE, hi=0, lo=0, counter=0, stall_req=0, busy=0.
- **IDLE**
  - start & MULT/MULTU & !flush: latch operands, go to MUL.
  - start & DIV/DIVU & !flush & op_b!=0: latch |op_a|, |op_b| (raw for DIVU) and the sign bits; counter=0; go to DIV.
  - start & DIV/DIVU & op_b==0: go to DONE with lo=0xFFFFFFFF, hi=op_a.
  - start & MTHI / MTLO & !flush: hi / lo = op_a at this edge; stay IDLE.
- **MUL**: compute the 64-bit product (signed for MULT, unsigned for MULTU); {hi,lo} = product; go to DONE.
- **DIV**: one restoring step per cycle: shift remainder left, bring in the next dividend bit, subtract the divisor if no borrow, and set the quotient bit.
  - After 32 steps, apply the signs:
    - DIV quotient negated if the operand signs differ.
    - DIV remainder takes the dividend sign.
  - lo = quotient, hi = remainder; go to DONE.
  - 0x80000000 / 0xFFFFFFFF (DIV) yields lo=0x80000000, hi=0.
- **DONE**: stall_req=0, so the pipeline advances. start is ignored in this cycle because it still belongs to the finished op. Go to IDLE.
- flush in any state: next state IDLE, no HI/LO write, counter cleared.

## Timing
- stall_req = !flush & ((IDLE & start & funct∈{MULT,MULTU,DIV,DIVU}) | MUL | DIV); combinational.
- MULT/MULTU: 2 stall cycles. HI/LO valid in the DONE cycle; the instruction leaves EX at the end of DONE.
- DIV/DIVU: 33 stall cycles (issue + 32 steps), then DONE. Divide-by-zero: 1 stall cycle, then DONE.
- MTHI/MTLO: 0 stall; the new value is visible on hi/lo in the next cycle.
- hi/lo are registered outputs and change only at the rising clk edge in MUL, in the final DIV step, on divide-by-zero issue, or on MTHI/MTLO.
- Reset asserted mid-operation clears everything immediately; the in-flight result is lost.
- flush on the same cycle as the final DIV step: no write, IDLE.

## Test plan
- **Reset**: rst_n low mid-DIV (step 12) → hi=lo=0, stall_req=0, busy=0 asynchronously; after release, IDLE.
- **MULT**: op_a=0xFFFFFFFD (−3), op_b=5 → stall_req high exactly 2 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU with the same operands → hi=0x00000004, lo=0xFFFFFFF1.
- **DIVU**: 100/7 → stall_req high 33 cycles; lo=14, hi=2. DIV 0xFFFFFFF9/2 (−7/2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **Divide by zero**: DIVU 0x12345678/0 → 1 stall cycle; lo=0xFFFFFFFF, hi=0x12345678.
- **Flush mid-divide**: preload hi=0xAAAA0000, lo=0x5555 via MTHI/MTLO; start DIVU 100/7; flush at step 10 → stall_req drops in that cycle, state IDLE next cycle, hi/lo unchanged.
- **Back-to-back**: MULT 6*7 immediately followed by MTLO 0x1 → after MULT DONE, lo=42 for one cycle, then lo=1; the second op causes no stall.
